convclk_ffrdstream: RTL and testbench

- Read-side prefetch stage that sits directly downstream of the dual-clock gray-pointer FIFO controller, in the read clock domain.
- Drives the controller's read strobe from its not-empty flag and captures the data the FIFO RAM returns at the controller's read address.
- Presents that data as a valid/ready stream through a small skid buffer, so downstream logic (e.g. the Keccak absorb front end) sees registered data, full throughput and backpressure.
- Honours the controller's read-side flush by discarding buffered and in-flight words.

---
 rtl/convclk_ffrdstream.sv | 121 ++++++++++++
 tb/tb_convclk_ffrdstream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/convclk_ffrdstream.sv
// Read-side prefetch stage for the gray-pointer FIFO: issues credit-limited reads and streams RAM data through a skid buffer.
// Optional build macro CONVCLK_FFRDSTREAM_PARITY_EN stores even parity with each word and drives it on o_par.
module convclk_ffrdstream #(
    parameter int DW     = 32,
    parameter int RAMLAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifonemp,
    input  logic                        rdflush,
    output logic                        fiford,
    input  logic [DW-1:0]               ramdat,
    output logic                        o_vld,
    input  logic                        o_rdy,
    output logic [DW-1:0]               o_dat,
    output logic                        o_par,
    output logic [$clog2(RAMLAT+2)-1:0] bufcnt
);

    localparam int SKID = RAMLAT + 1;
    localparam int CW   = $clog2(SKID + 1);
    localparam int PW   = (SKID > 1) ? $clog2(SKID) : 1;
    localparam int IW   = CW + 1;
    localparam int SW   = CW + 2;

`ifdef CONVCLK_FFRDSTREAM_PARITY_EN
    localparam int EW = DW + 1;
`else
    localparam int EW = DW;
`endif

    logic [EW-1:0]     mem_reg [SKID];
    logic [PW-1:0]     head_reg;
    logic [PW-1:0]     tail_reg;
    logic [CW-1:0]     cnt_reg;
    logic [RAMLAT-1:0] tag_reg;

    logic              pop;
    logic              push_w;
    logic              push_ok;
    logic [IW-1:0]     inflight;
    logic [SW-1:0]     credit;
    logic [EW-1:0]     wdata;
    logic [EW-1:0]     head_ent;

    assign o_vld   = (cnt_reg != '0);
    assign pop     = o_vld & o_rdy;
    assign push_w  = tag_reg[RAMLAT-1];
    assign push_ok = push_w & ~rdflush;
    assign bufcnt  = cnt_reg;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAMLAT; i++) begin
            inflight = inflight + IW'(tag_reg[i]);
        end
    end

    // Words already requested count against buffer space, so the buffer can never overflow.
    assign credit = SW'(cnt_reg) + SW'(inflight) - SW'(pop);
    assign fiford = fifonemp & ~rdflush & ~rst & (credit < SW'(SKID));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_reg <= '0;
        end else if (rdflush) begin
            tag_reg <= '0;
        end else begin
            for (int i = RAMLAT - 1; i > 0; i--) begin
                tag_reg[i] <= tag_reg[i-1];
            end
            tag_reg[0] <= fiford;
        end
    end

`ifdef CONVCLK_FFRDSTREAM_PARITY_EN
    assign wdata = {^ramdat, ramdat};
    assign o_par = head_ent[DW];
`else
    assign wdata = ramdat;
    assign o_par = 1'b0;
`endif

    assign head_ent = mem_reg[head_reg];
    assign o_dat    = head_ent[DW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push_ok) begin
            mem_reg[tail_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg <= '0;
            tail_reg <= '0;
            cnt_reg  <= '0;
        end else if (rdflush) begin
            head_reg <= '0;
            tail_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            if (pop) begin
                head_reg <= (head_reg == PW'(SKID - 1)) ? '0 : head_reg + 1'b1;
            end
            if (push_ok) begin
                tail_reg <= (tail_reg == PW'(SKID - 1)) ? '0 : tail_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   cnt_reg <= cnt_reg + CW'(1);
                2'b01:   cnt_reg <= cnt_reg - CW'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_convclk_ffrdstream.sv
// Directed bench for convclk_ffrdstream (RAMLAT=1) with a small FIFO/RAM model driving ramdat one cycle after fiford.
module tb_convclk_ffrdstream;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifonemp;
    logic          rdflush = 1'b0;
    logic          fiford;
    logic [DW-1:0] ramdat = '0;
    logic          o_vld;
    logic          o_rdy = 1'b0;
    logic [DW-1:0] o_dat;
    logic          o_par;
    logic [1:0]    bufcnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        nemp_en = 1'b0;
    logic        fifo_clr = 1'b0;

    logic        g_nemp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        g_rd   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        g_vld  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] g_dat  [7] = '{32'h0, 32'h0, 32'h40, 32'h0, 32'h0, 32'h41, 32'h0};

    convclk_ffrdstream #(.DW(DW), .RAMLAT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .fifonemp (fifonemp),
        .rdflush  (rdflush),
        .fiford   (fiford),
        .ramdat   (ramdat),
        .o_vld    (o_vld),
        .o_rdy    (o_rdy),
        .o_dat    (o_dat),
        .o_par    (o_par),
        .bufcnt   (bufcnt)
    );

    always #5 clk = ~clk;

    assign fifonemp = nemp_en && (rd_ptr != wr_ptr);

    // FIFO controller + RAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (fiford) begin
            ramdat <= fifo_mem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("chk %-12s obs=%0h exp=%0h ok", tag, obs, exp);
        end
    endtask

    // A push into a full buffer without a simultaneous pop would lose a word.
    always @(negedge clk) begin
        if (!rst && dut.push_w) begin
            chk("no_ovf", {31'b0, (bufcnt == 2'd2) && !(o_vld && o_rdy)}, 32'h0);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] v);
        int idx;
        idx = wr_ptr % 64;
        fifo_mem[idx[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            put_word(base + 32'(i));
        end
    endtask

    task automatic clear_fifo;
        fifo_clr = 1'b1;
        step();
        fifo_clr = 1'b0;
    endtask

    initial begin
        int n;
        int pulses;
        logic exp_p0;
        logic exp_p1;

        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_vld", o_vld, 0);
        chk("rst_rd", fiford, 0);
        chk("rst_cnt", bufcnt, 0);
        chk("rst_dat", o_dat, 0);
        chk("rst_par", o_par, 0);
        rst = 1'b0;
        step();

        // Streaming, o_rdy=1
        load(32'h10, 8);
        nemp_en = 1'b1;
        o_rdy = 1'b1;
        #1;
        n = 0;
        while (!fiford && n < 10) begin
            step();
            n++;
        end
        chk("t2_issue", fiford, 1);
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            chk("t2_vld", o_vld, 1);
            chk("t2_dat", o_dat, 32'h10 + 32'(i));
            step();
        end
        chk("t2_idle", o_vld, 0);

        // Backpressure
        nemp_en = 1'b0;
        o_rdy = 1'b0;
        clear_fifo();
        load(32'h10, 8);
        nemp_en = 1'b1;
        #1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            pulses += int'(fiford);
            if (i >= 2) chk("t3_hold", o_dat, 32'h10);
            step();
        end
        chk("t3_pulses", pulses, 2);
        chk("t3_cnt", bufcnt, 2);
        chk("t3_vld", o_vld, 1);
        o_rdy = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_vld", o_vld, 1);
            chk("t3_dat", o_dat, 32'h10 + 32'(i));
            step();
        end
        chk("t3_idle", o_vld, 0);

        // Flush with one word buffered and one in flight
        nemp_en = 1'b0;
        o_rdy = 1'b0;
        clear_fifo();
        load(32'h30, 8);
        nemp_en = 1'b1;
        #1;
        chk("t4_rd0", fiford, 1);
        step();
        chk("t4_rd1", fiford, 1);
        step();
        chk("t4_cnt1", bufcnt, 1);
        rdflush = 1'b1;
        #1;
        chk("t4_rdoff", fiford, 0);
        step();
        rdflush = 1'b0;
        #1;
        chk("t4_vld0", o_vld, 0);
        chk("t4_cnt0", bufcnt, 0);
        chk("t4_resume", fiford, 1);
        o_rdy = 1'b1;
        step();
        chk("t4_drop", o_vld, 0);
        step();
        chk("t4_vld1", o_vld, 1);
        chk("t4_first", o_dat, 32'h32);
        step();
        chk("t4_next", o_dat, 32'h33);
        nemp_en = 1'b0;
        repeat (4) step();
        chk("t4_drain", bufcnt, 0);

        // fifonemp gaps
        clear_fifo();
        load(32'h40, 2);
        o_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            nemp_en = g_nemp[i];
            #1;
            chk("t5_rd", fiford, 32'(g_rd[i]));
            chk("t5_vld", o_vld, 32'(g_vld[i]));
            if (g_vld[i]) chk("t5_dat", o_dat, g_dat[i]);
            step();
        end

        // Parity
        nemp_en = 1'b0;
        clear_fifo();
        put_word(32'h1);
        put_word(32'h3);
`ifdef CONVCLK_FFRDSTREAM_PARITY_EN
        exp_p0 = 1'b1;
        exp_p1 = 1'b0;
`else
        exp_p0 = 1'b0;
        exp_p1 = 1'b0;
`endif
        nemp_en = 1'b1;
        o_rdy = 1'b1;
        #1;
        step();
        step();
        chk("t6_vld0", o_vld, 1);
        chk("t6_dat0", o_dat, 32'h1);
        chk("t6_par0", o_par, 32'(exp_p0));
        step();
        chk("t6_vld1", o_vld, 1);
        chk("t6_dat1", o_dat, 32'h3);
        chk("t6_par1", o_par, 32'(exp_p1));
        nemp_en = 1'b0;
        repeat (3) step();

        // Reset mid-stream with a full buffer
        o_rdy = 1'b0;
        clear_fifo();
        load(32'h50, 4);
        nemp_en = 1'b1;
        #1;
        n = 0;
        while (bufcnt != 2'd2 && n < 10) begin
            step();
            n++;
        end
        chk("t7_full", bufcnt, 2);
        rst = 1'b1;
        #1;
        chk("t7_vld", o_vld, 0);
        chk("t7_rd", fiford, 0);
        chk("t7_cnt", bufcnt, 0);
        chk("t7_dat", o_dat, 0);
        step();
        nemp_en = 1'b0;
        rst = 1'b0;
        clear_fifo();
        for (int i = 0; i < 4; i++) begin
            chk("t7_idle_v", o_vld, 0);
            chk("t7_idle_r", fiford, 0);
            chk("t7_idle_c", bufcnt, 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
